// File: rtl/edge_pkg.sv
// Shared types and sizing for the Sobel edge-detection row stage.
package edge_pkg;

  localparam int PIX_W   = 8;
  localparam int ROW_PIX = 20;
  localparam int COL_W   = 5;
  localparam int IDX_W   = 16;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t [ROW_PIX-1:0] pixel_row_t;
  // One 3-pixel column of the window: [0] = oldest row, [2] = newest row
  typedef pixel_t [2:0] pixel_col_t;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    OUTPUT
  } sobel_state_t;

endpackage

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel magnitude for one output column, with saturation and thresholding.
module sobel_kernel
  import edge_pkg::*;
(
  input  pixel_col_t left,
  input  pixel_col_t mid,
  input  pixel_col_t right,
  input  pixel_t     threshold,
  output pixel_t     res
);

  // a + 2b + c, at most 1020, so it stays positive as an 11-bit signed value
  function automatic logic [10:0] weighted_sum(input pixel_t a, input pixel_t b, input pixel_t c);
    return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
  endfunction

  function automatic logic [10:0] abs11(input logic signed [10:0] v);
    logic [10:0] r;
    r = v[10] ? -v : v;
    return r;
  endfunction

  function automatic pixel_t sat_thresh(input logic [11:0] mag, input pixel_t thr);
    pixel_t s;
    s = (mag > 12'd255) ? 8'hFF : mag[7:0];
    return (s < thr) ? '0 : s;
  endfunction

  logic signed [10:0] gx;
  logic signed [10:0] gy;
  logic [11:0]        mag;

  assign gx  = $signed(weighted_sum(right[0], right[1], right[2]))
             - $signed(weighted_sum(left[0], left[1], left[2]));
  assign gy  = $signed(weighted_sum(left[2], mid[2], right[2]))
             - $signed(weighted_sum(left[0], mid[0], right[0]));
  assign mag = {1'b0, abs11(gx)} + {1'b0, abs11(gy)};
  assign res = sat_thresh(mag, threshold);

endmodule

// File: rtl/sobel_row_stage.sv
// Three-row sliding window feeding a column-serial Sobel kernel; one result row per accepted row.
module sobel_row_stage #(
  parameter int ROW_PIX = edge_pkg::ROW_PIX,
  parameter int PIX_W   = edge_pkg::PIX_W
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           frame_start,
  input  logic                           row_valid,
  input  logic [ROW_PIX-1:0][PIX_W-1:0]  row_in,
  output logic                           row_ready,
  input  logic [PIX_W-1:0]               threshold,
  output logic                           result_valid,
  input  logic                           result_ack,
  output logic [ROW_PIX-1:0][PIX_W-1:0]  result_out,
  output logic [15:0]                    out_row,
  output logic                           busy
);

  localparam int COL_W = edge_pkg::COL_W;
  localparam logic [COL_W-1:0] FIRST_COL = COL_W'(1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(ROW_PIX - 2);

  edge_pkg::sobel_state_t state, state_next;
  logic [1:0]       rows_loaded, rows_next;
  logic [COL_W-1:0] col, col_next, col_l, col_r;
  logic             load_row, write_res, bump_row;
  logic [15:0]      row_idx;

  logic [ROW_PIX-1:0][PIX_W-1:0] w0, w1, w2, res;
  edge_pkg::pixel_t              kern_res;

  always_comb begin
    state_next = state;
    rows_next  = rows_loaded;
    col_next   = col;
    load_row   = 1'b0;
    write_res  = 1'b0;
    bump_row   = 1'b0;
    if (frame_start) begin
      state_next = edge_pkg::IDLE;
      rows_next  = 2'd0;
    end else begin
      case (state)
        edge_pkg::IDLE: begin
          if (row_valid) begin
            load_row  = 1'b1;
            rows_next = (rows_loaded == 2'd3) ? 2'd3 : rows_loaded + 2'd1;
            if (rows_next == 2'd3) begin
              state_next = edge_pkg::COMPUTE;
              col_next   = FIRST_COL;
            end
          end
        end
        edge_pkg::COMPUTE: begin
          write_res = 1'b1;
          if (col == LAST_COL) begin
            state_next = edge_pkg::OUTPUT;
            bump_row   = 1'b1;
          end else begin
            col_next = col + COL_W'(1);
          end
        end
        edge_pkg::OUTPUT: begin
          if (result_ack) state_next = edge_pkg::IDLE;
        end
        default: state_next = edge_pkg::IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= edge_pkg::IDLE;
      rows_loaded <= 2'd0;
      col         <= FIRST_COL;
      row_idx     <= 16'd0;
      res         <= '0;
    end else begin
      state       <= state_next;
      rows_loaded <= rows_next;
      col         <= col_next;
      if (frame_start)   row_idx <= 16'd0;
      else if (bump_row) row_idx <= row_idx + 16'd1;
      // Border columns are never written and keep their reset value of zero
      if (write_res) res[col] <= kern_res;
    end
  end

  always_ff @(posedge clk) begin
    if (load_row) begin
      w0 <= w1;
      w1 <= w2;
      w2 <= row_in;
    end
  end

  // col is confined to 1..ROW_PIX-2, so both neighbours are always in range
  assign col_l = col - COL_W'(1);
  assign col_r = col + COL_W'(1);

  sobel_kernel u_kernel (
    .left      ({w2[col_l], w1[col_l], w0[col_l]}),
    .mid       ({w2[col],   w1[col],   w0[col]}),
    .right     ({w2[col_r], w1[col_r], w0[col_r]}),
    .threshold (threshold),
    .res       (kern_res)
  );

  assign row_ready    = (state == edge_pkg::IDLE);
  assign busy         = (state != edge_pkg::IDLE);
  assign result_valid = (state == edge_pkg::OUTPUT);
  assign result_out   = res;
  assign out_row      = row_idx;

endmodule
